traffic_phase_ctrl: RTL and testbench

- Parametrised traffic-light sequencer for an intersection with `NUM_CH` vehicle approaches and one pedestrian crossing.
- Cycles approaches green → yellow → all-red with programmable durations, in round-robin order.
- Serves latched pedestrian requests and supports a blinking-yellow night mode.
- Drives 3-bit RGB lamp codes directly to the board LED outputs.

---
 rtl/traffic_pkg.sv | 57 +++++
 rtl/traffic_phase_ctrl_color_dec.sv | 49 ++++
 rtl/traffic_phase_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
//   Shared definitions for the traffic phase controller:
//     - state_t      : controller phase encoding
//     - LAMP_*       : 3-bit RGB lamp codes driven straight onto the board LEDs
//     - next_ch_t    : result of the round-robin approach search
//     - next_unmasked: finds the next approach after 'cur' (cyclic) whose skip
//                      bit is clear; 'cur' itself is the last candidate.
// -----------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_ALL_RED   = 3'd0,
        ST_GREEN     = 3'd1,
        ST_YELLOW    = 3'd2,
        ST_PED_WALK  = 3'd3,
        ST_PED_CLEAR = 3'd4,
        ST_NIGHT     = 3'd5
    } state_t;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_GREEN  = 3'b010;
    localparam logic [2:0] LAMP_YELLOW = 3'b110;
    localparam logic [2:0] LAMP_OFF    = 3'b000;

    // Largest supported number of approaches; the search works on masks and
    // indices padded to this size.
    localparam int MAX_CH = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] ch;
    } next_ch_t;

    // Scans from the farthest candidate back to the nearest so that the nearest
    // unmasked approach is the one left in the result.
    function automatic next_ch_t next_unmasked(
        input logic [2:0]        cur,
        input logic [MAX_CH-1:0] skip,
        input int                num_ch
    );
        next_ch_t res;
        int       idx;
        res = '0;
        for (int k = MAX_CH; k >= 1; k--) begin
            if (k <= num_ch) begin
                idx = (int'(cur) + k) % num_ch;
                if (!skip[idx[2:0]]) begin
                    res.found = 1'b1;
                    res.ch    = idx[2:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/traffic_phase_ctrl_color_dec.sv
// -----------------------------------------------------------------------------
// traffic_color_dec
//   Pure combinational lamp decoder. Turns the controller phase, the current
//   approach and the night blink phase into lamp codes.
//   Ports:
//     state   in  state_t            controller phase
//     cur_ch  in  $clog2(NUM_CH)     current / last served approach
//     blink   in  1                  night blink phase (1 = lamps on)
//     ch_rgb  out 3*NUM_CH           approach i lamp at [3i+2:3i]
//     ped_rgb out 3                  pedestrian lamp
// -----------------------------------------------------------------------------
module traffic_color_dec
    import traffic_pkg::*;
#(
    parameter int NUM_CH = 3
) (
    input  state_t                      state,
    input  logic [$clog2(NUM_CH)-1:0]   cur_ch,
    input  logic                        blink,
    output logic [3*NUM_CH-1:0]         ch_rgb,
    output logic [2:0]                  ped_rgb
);

    // NOTE: every output gets a default at the top of the block; any path that
    // skipped an assignment would otherwise infer a latch.
    always_comb begin
        ped_rgb = LAMP_RED;
        case (state)
            ST_PED_WALK:  ped_rgb = LAMP_GREEN;
            ST_PED_CLEAR: ped_rgb = LAMP_YELLOW;
            ST_NIGHT:     ped_rgb = LAMP_OFF;
            default:      ped_rgb = LAMP_RED;
        endcase

        for (int i = 0; i < NUM_CH; i++) begin
            ch_rgb[3*i +: 3] = LAMP_RED;
            if (state == ST_NIGHT) begin
                ch_rgb[3*i +: 3] = blink ? LAMP_YELLOW : LAMP_OFF;
            end else if (i == int'(cur_ch)) begin
                if (state == ST_GREEN) begin
                    ch_rgb[3*i +: 3] = LAMP_GREEN;
                end else if (state == ST_YELLOW) begin
                    ch_rgb[3*i +: 3] = LAMP_YELLOW;
                end
            end
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_phase_ctrl
//   Round-robin traffic-light sequencer for NUM_CH approaches plus one
//   pedestrian crossing, with latched pedestrian requests and a blinking
//   yellow night mode. All durations are in ticks of TICK_DIV clocks.
//   Ports:
//     clk        in  1             system clock
//     rst        in  1             synchronous active-high reset
//     en         in  1             run enable; 0 freezes counters and phase
//     night      in  1             request blinking-yellow mode
//     ped_req    in  1             pedestrian button (any pulse width)
//     skip_mask  in  NUM_CH        bit i set: approach i is skipped
//     ch_rgb     out 3*NUM_CH      approach lamps, approach i at [3i+2:3i]
//     ped_rgb    out 3             pedestrian lamp
//     cur_ch     out clog2(NUM_CH) current / last served approach
//     ped_ack    out 1             one-cycle pulse in the first PED_WALK cycle
// -----------------------------------------------------------------------------
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int TICK_DIV = 100_000_000,
    parameter int CNT_W    = 8,
    parameter int GREEN_T  = 10,
    parameter int YELLOW_T = 3,
    parameter int ALLRED_T = 1,
    parameter int PED_T    = 8,
    parameter int BLINK_T  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        night,
    input  logic                        ped_req,
    input  logic [NUM_CH-1:0]           skip_mask,
    output logic [3*NUM_CH-1:0]         ch_rgb,
    output logic [2:0]                  ped_rgb,
    output logic [$clog2(NUM_CH)-1:0]   cur_ch,
    output logic                        ped_ack
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);

    state_t             state, state_nxt;
    logic [PS_W-1:0]    presc;
    logic [CNT_W-1:0]   timer;
    logic               blink, blink_nxt;
    logic               ped_pend;
    logic [CH_W-1:0]    cur_nxt;
    logic               restart;
    logic               tick;
    logic               expire;
    logic               enter_walk;
    logic               enter_night;
    logic               pend_open;
    next_ch_t           nc;

    // Timer reload value for the phase being entered. PED_CLEAR reuses the
    // yellow duration; ALL_RED is also the fallback for any unused encoding.
    function automatic logic [CNT_W-1:0] reload_val(input state_t s);
        case (s)
            ST_GREEN:                return CNT_W'(GREEN_T - 1);
            ST_YELLOW, ST_PED_CLEAR: return CNT_W'(YELLOW_T - 1);
            ST_PED_WALK:             return CNT_W'(PED_T - 1);
            ST_NIGHT:                return CNT_W'(BLINK_T - 1);
            default:                 return CNT_W'(ALLRED_T - 1);
        endcase
    endfunction

    assign tick   = en && (presc == PS_MAX);
    assign expire = tick && (timer == '0);

    assign nc = next_unmasked(3'(cur_ch), MAX_CH'(skip_mask), NUM_CH);

    // Requests are only accepted while the crossing is not already being
    // served and night mode is not active.
    assign pend_open = (state != ST_PED_WALK) && (state != ST_PED_CLEAR) &&
                       (state != ST_NIGHT);

    // Phase changes only happen on enabled cycles, so these are implicitly
    // gated by en.
    assign enter_walk  = (state_nxt == ST_PED_WALK) && (state != ST_PED_WALK);
    assign enter_night = (state_nxt == ST_NIGHT)    && (state != ST_NIGHT);

    // Next-state logic. 'restart' reloads the prescaler and timer; it is raised
    // on every phase entry and on the in-place reloads (all approaches masked,
    // night blink toggle).
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur_ch;
        blink_nxt = blink;
        restart   = 1'b0;

        case (state)
            ST_ALL_RED: begin
                if (expire) begin
                    restart = 1'b1;
                    if (night) begin
                        state_nxt = ST_NIGHT;
                        blink_nxt = 1'b1;
                    end else if (ped_pend) begin
                        state_nxt = ST_PED_WALK;
                    end else if (nc.found) begin
                        state_nxt = ST_GREEN;
                        cur_nxt   = CH_W'(nc.ch);
                    end
                end
            end
            ST_GREEN: begin
                if (expire) begin
                    state_nxt = ST_YELLOW;
                    restart   = 1'b1;
                end
            end
            ST_YELLOW: begin
                if (expire) begin
                    state_nxt = ST_ALL_RED;
                    restart   = 1'b1;
                end
            end
            ST_PED_WALK: begin
                if (expire) begin
                    state_nxt = ST_PED_CLEAR;
                    restart   = 1'b1;
                end
            end
            ST_PED_CLEAR: begin
                if (expire) begin
                    state_nxt = ST_ALL_RED;
                    restart   = 1'b1;
                end
            end
            ST_NIGHT: begin
                // Leaving night mode does not wait for a tick.
                if (en && !night) begin
                    state_nxt = ST_ALL_RED;
                    restart   = 1'b1;
                end else if (expire) begin
                    blink_nxt = ~blink;
                    restart   = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_ALL_RED;
                restart   = 1'b1;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_ALL_RED;
            cur_ch   <= CH_W'(NUM_CH - 1);
            presc    <= '0;
            timer    <= CNT_W'(ALLRED_T - 1);
            blink    <= 1'b1;
            ped_pend <= 1'b0;
            ped_ack  <= 1'b0;
        end else begin
            ped_ack <= enter_walk;

            // Clearing wins, so a press in the entry cycle is absorbed by the
            // walk that is starting. Latching is independent of en.
            if (enter_walk || enter_night) begin
                ped_pend <= 1'b0;
            end else if (ped_req && pend_open) begin
                ped_pend <= 1'b1;
            end

            if (en) begin
                state  <= state_nxt;
                cur_ch <= cur_nxt;
                blink  <= blink_nxt;
                if (restart) begin
                    presc <= '0;
                    timer <= reload_val(state_nxt);
                end else if (tick) begin
                    presc <= '0;
                    timer <= timer - 1'b1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

    traffic_color_dec #(
        .NUM_CH (NUM_CH)
    ) u_color_dec (
        .state   (state),
        .cur_ch  (cur_ch),
        .blink   (blink),
        .ch_rgb  (ch_rgb),
        .ped_rgb (ped_rgb)
    );

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// -----------------------------------------------------------------------------
// tb_traffic_phase_ctrl
//   Scenario tasks drive the controller and compare every cycle against a
//   reference model that tracks "phase + enabled cycles left in the phase".
//   Directed checks cover the lamp sequences, counts and corner cases.
// -----------------------------------------------------------------------------
module tb_traffic_phase_ctrl;

    localparam int N   = 3;
    localparam int TD  = 4;
    localparam int GT  = 3;
    localparam int YT  = 2;
    localparam int AT  = 1;
    localparam int PT  = 2;
    localparam int BT  = 1;

    // Model phases
    localparam int P_AR = 0;
    localparam int P_GR = 1;
    localparam int P_YE = 2;
    localparam int P_WK = 3;
    localparam int P_CL = 4;
    localparam int P_NT = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b0;
    logic           night = 1'b0;
    logic           ped_req = 1'b0;
    logic [N-1:0]   skip_mask = '0;
    logic [3*N-1:0] ch_rgb;
    logic [2:0]     ped_rgb;
    logic [1:0]     cur_ch;
    logic           ped_ack;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int m_phase = P_AR;
    int m_left  = AT * TD;
    int m_cur   = N - 1;
    bit m_pend  = 1'b0;
    bit m_blink = 1'b1;
    bit m_ack   = 1'b0;

    traffic_phase_ctrl #(
        .NUM_CH   (N),
        .TICK_DIV (TD),
        .CNT_W    (8),
        .GREEN_T  (GT),
        .YELLOW_T (YT),
        .ALLRED_T (AT),
        .PED_T    (PT),
        .BLINK_T  (BT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .night     (night),
        .ped_req   (ped_req),
        .skip_mask (skip_mask),
        .ch_rgb    (ch_rgb),
        .ped_rgb   (ped_rgb),
        .cur_ch    (cur_ch),
        .ped_ack   (ped_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Model: one clock edge with the inputs currently applied.
    task automatic model_step();
        int  nxt;
        bit  walk_in;
        bit  night_in;
        bit  found;
        int  c;
        if (rst) begin
            m_phase = P_AR; m_left = AT * TD; m_cur = N - 1;
            m_pend = 1'b0; m_blink = 1'b1; m_ack = 1'b0;
            return;
        end
        nxt = m_phase; walk_in = 1'b0; night_in = 1'b0;
        if (en) begin
            if (m_phase == P_NT && !night) begin
                nxt = P_AR; m_left = AT * TD;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    case (m_phase)
                        P_AR: begin
                            if (night) begin
                                nxt = P_NT; m_left = BT * TD; m_blink = 1'b1; night_in = 1'b1;
                            end else if (m_pend) begin
                                nxt = P_WK; m_left = PT * TD; walk_in = 1'b1;
                            end else begin
                                found = 1'b0;
                                for (int k = 1; k <= N; k++) begin
                                    c = (m_cur + k) % N;
                                    if (!found && !skip_mask[c]) begin
                                        found = 1'b1; m_cur = c;
                                    end
                                end
                                if (found) nxt = P_GR;
                                m_left = (found ? GT : AT) * TD;
                            end
                        end
                        P_GR: begin nxt = P_YE; m_left = YT * TD; end
                        P_YE: begin nxt = P_AR; m_left = AT * TD; end
                        P_WK: begin nxt = P_CL; m_left = YT * TD; end
                        P_CL: begin nxt = P_AR; m_left = AT * TD; end
                        default: begin m_blink = !m_blink; m_left = BT * TD; end
                    endcase
                end
            end
        end
        if (walk_in || night_in) m_pend = 1'b0;
        else if (ped_req && m_phase != P_WK && m_phase != P_CL && m_phase != P_NT) m_pend = 1'b1;
        m_ack   = walk_in;
        m_phase = nxt;
    endtask

    function automatic logic [14:0] expected();
        logic [8:0] ch;
        logic [2:0] pd;
        for (int i = 0; i < N; i++) begin
            ch[3*i +: 3] = 3'b100;
            if (m_phase == P_NT)                    ch[3*i +: 3] = m_blink ? 3'b110 : 3'b000;
            else if (i == m_cur && m_phase == P_GR) ch[3*i +: 3] = 3'b010;
            else if (i == m_cur && m_phase == P_YE) ch[3*i +: 3] = 3'b110;
        end
        case (m_phase)
            P_WK:    pd = 3'b010;
            P_CL:    pd = 3'b110;
            P_NT:    pd = 3'b000;
            default: pd = 3'b100;
        endcase
        return {ch, pd, 2'(m_cur), m_ack};
    endfunction

    function automatic logic [14:0] observed();
        return {ch_rgb, ped_rgb, cur_ch, ped_ack};
    endfunction

    function automatic int green_ch();
        for (int i = 0; i < N; i++) if (ch_rgb[3*i +: 3] == 3'b010) return i;
        return -1;
    endfunction

    // One clock edge; outputs are then observed at the falling edge.
    task automatic advance();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; night = 1'b0; ped_req = 1'b0; skip_mask = '0;
        for (int c = 0; c < 2; c++) begin
            advance();
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL reset_model cyc %0d: got %b required %b", c, observed(), expected());
            end
        end
        vectors++;
        if (observed() !== {9'b100100100, 3'b100, 2'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_values: got %b required %b", observed(), {9'b100100100, 3'b100, 2'd2, 1'b0});
        end
        rst = 1'b0;
    endtask

    task automatic test_rotation();
        int seq[$];
        int prev = -1;
        int g;
        for (int c = 0; c < 80; c++) begin
            advance();
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL rotation cyc %0d: got %b required %b", c, observed(), expected());
            end
            g = green_ch();
            if (g >= 0 && g != prev) seq.push_back(g);
            prev = g;
            if (c == 3) begin
                vectors++;
                if (ch_rgb !== 9'b100100010) begin
                    miscompares++;
                    $display("FAIL rotation_first_green: got %b required %b", ch_rgb, 9'b100100010);
                end
            end
        end
        vectors++;
        if (seq.size() != 4 || seq[0] != 0 || seq[1] != 1 || seq[2] != 2 || seq[3] != 0) begin
            miscompares++;
            $display("FAIL rotation_order: got %p required '{0,1,2,0}", seq);
        end
    endtask

    task automatic test_ped();
        int walk_n = 0, clear_n = 0, ack_n = 0, after = -1;
        bit walked = 1'b0;
        rst = 1'b1; advance(); rst = 1'b0;
        for (int c = 0; c < 67; c++) begin
            ped_req = (c == 6);
            advance();
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL ped cyc %0d: got %b required %b", c, observed(), expected());
            end
            if (ped_rgb == 3'b010) begin walk_n++; walked = 1'b1; end
            if (ped_rgb == 3'b110) clear_n++;
            if (ped_ack) ack_n++;
            if (walked && after < 0 && green_ch() >= 0) after = green_ch();
        end
        ped_req = 1'b0;
        vectors++;
        if (walk_n != 8 || clear_n != 8 || ack_n != 1 || after != 1) begin
            miscompares++;
            $display("FAIL ped_phase: got walk=%0d clear=%0d ack=%0d next=%0d required walk=8 clear=8 ack=1 next=1",
                     walk_n, clear_n, ack_n, after);
        end
    endtask

    task automatic test_skip();
        int seq[$];
        int prev = -1, g, late_greens = 0, walk_n = 0;
        rst = 1'b1; advance(); rst = 1'b0;
        skip_mask = 3'b010;
        for (int c = 0; c < 180; c++) begin
            if (c == 60) skip_mask = 3'b111;
            ped_req = (c == 150);
            advance();
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL skip cyc %0d: got %b required %b", c, observed(), expected());
            end
            g = green_ch();
            if (c < 60 && g >= 0 && g != prev) seq.push_back(g);
            prev = g;
            if (c >= 90 && c < 150 && ch_rgb != 9'b100100100) late_greens++;
            if (ped_rgb == 3'b010) walk_n++;
        end
        ped_req = 1'b0;
        skip_mask = '0;
        vectors++;
        if (seq.size() != 3 || seq[0] != 0 || seq[1] != 2 || seq[2] != 0) begin
            miscompares++;
            $display("FAIL skip_order: got %p required '{0,2,0}", seq);
        end
        vectors++;
        if (late_greens != 0 || walk_n != 8) begin
            miscompares++;
            $display("FAIL skip_all_masked: got non_red=%0d walk=%0d required non_red=0 walk=8", late_greens, walk_n);
        end
    endtask

    task automatic test_night();
        int on_n = 0, off_n = 0;
        rst = 1'b1; advance(); rst = 1'b0;
        for (int c = 0; c < 90; c++) begin
            if (c == 30) night = 1'b1;
            advance();
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL night cyc %0d: got %b required %b", c, observed(), expected());
            end
            if (ch_rgb == 9'b110110110 && ped_rgb == 3'b000) on_n++;
            if (ch_rgb == 9'b000000000 && ped_rgb == 3'b000) off_n++;
        end
        vectors++;
        if (on_n < 8 || off_n < 8) begin
            miscompares++;
            $display("FAIL night_blink: got on=%0d off=%0d required at least 8 each", on_n, off_n);
        end
        night = 1'b0;
        advance();
        vectors++;
        if (ch_rgb !== 9'b100100100 || ped_rgb !== 3'b100) begin
            miscompares++;
            $display("FAIL night_exit: got ch=%b ped=%b required ch=100100100 ped=100", ch_rgb, ped_rgb);
        end
        for (int c = 0; c < 8; c++) begin
            advance();
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL night_after cyc %0d: got %b required %b", c, observed(), expected());
            end
        end
    endtask

    task automatic test_hold();
        int yel_n = 0;
        rst = 1'b1; advance(); rst = 1'b0;
        for (int c = 0; c < 49; c++) begin
            en = !(c >= 19 && c < 29);
            advance();
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL hold cyc %0d: got %b required %b", c, observed(), expected());
            end
            if (ch_rgb == 9'b100100110) yel_n++;
        end
        en = 1'b1;
        vectors++;
        if (yel_n != 18) begin
            miscompares++;
            $display("FAIL hold_yellow_len: got %0d required 18", yel_n);
        end
    endtask

    task automatic test_rst_walk();
        int walk_n = 0;
        rst = 1'b1; advance(); rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            ped_req = (c == 0);
            advance();
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL rst_walk_pre cyc %0d: got %b required %b", c, observed(), expected());
            end
        end
        rst = 1'b1; ped_req = 1'b1;
        advance();
        vectors++;
        if (observed() !== {9'b100100100, 3'b100, 2'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_walk_reset: got %b required %b", observed(), {9'b100100100, 3'b100, 2'd2, 1'b0});
        end
        rst = 1'b0; ped_req = 1'b0;
        for (int c = 0; c < 12; c++) begin
            advance();
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL rst_walk_post cyc %0d: got %b required %b", c, observed(), expected());
            end
            if (ped_rgb == 3'b010) walk_n++;
            if (c == 3) begin
                vectors++;
                if (ch_rgb !== 9'b100100010) begin
                    miscompares++;
                    $display("FAIL rst_walk_first_green: got %b required 100100010", ch_rgb);
                end
            end
        end
        vectors++;
        if (walk_n != 0) begin
            miscompares++;
            $display("FAIL rst_walk_discard: got walk=%0d required 0", walk_n);
        end
    endtask

    task automatic test_random();
        rst = 1'b0; en = 1'b1; night = 1'b0; ped_req = 1'b0; skip_mask = '0;
        for (int c = 0; c < 3000; c++) begin
            en      = ($urandom_range(0, 9) != 0);
            ped_req = ($urandom_range(0, 29) == 0);
            rst     = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 199) == 0) night = ~night;
            if ($urandom_range(0, 299) == 0) skip_mask = N'($urandom);
            advance();
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL random cyc %0d: got %b required %b", c, observed(), expected());
            end
        end
        rst = 1'b0; ped_req = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_rotation();
        test_ped();
        test_skip();
        test_night();
        test_hold();
        test_rst_walk();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
